// File: rtl/alu_control_seq_if.sv
// Request/result bundle between main control and alu_control_seq.
// Handshake: a request transfers on a cycle where valid_i & ready_o are both high; the producer holds valid_i/ALUOp/Funct until then.
interface alu_control_seq_if #(
  parameter int OP_W = 3
);
  logic            valid_i;
  logic [1:0]      ALUOp;
  logic [5:0]      Funct;
  logic            ready_o;
  logic [OP_W-1:0] Op;
  logic            op_valid;
  logic            illegal;
  logic            mdu_start;
  logic            mdu_div;
  logic            mdu_signed;
  logic            mdu_busy;
  logic            mdu_done;
  logic            hilo_we;
  logic            stall;
  logic [1:0]      dbg_state;

  modport master (
    output valid_i, ALUOp, Funct,
    input  ready_o, Op, op_valid, illegal, mdu_start, mdu_div, mdu_signed,
           mdu_busy, mdu_done, hilo_we, stall, dbg_state
  );

  modport slave (
    input  valid_i, ALUOp, Funct,
    output ready_o, Op, op_valid, illegal, mdu_start, mdu_div, mdu_signed,
           mdu_busy, mdu_done, hilo_we, stall, dbg_state
  );
endinterface

// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with a multiply/divide sequencer.
// Define ALUCTL_MDU_EN to build the MDU decode, FSM and busy counter; otherwise MDU functs decode as illegal.
module alu_control_seq #(
  parameter int OP_W       = 3,
  parameter int MUL_CYCLES = 32,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input logic               clk,
  input logic               reset,
  alu_control_seq_if.slave  bus
);

  if (OP_W < 3 || MUL_CYCLES < 1 || DIV_CYCLES < 1 ||
      MUL_CYCLES > (1 << CNT_W) || DIV_CYCLES > (1 << CNT_W)) begin : g_bad_params
    $error("alu_control_seq: parameter out of range");
  end

  logic            ready;
  logic            accept;
  logic [2:0]      dec_op;
  logic            dec_ill;
  logic            dec_mdu;
  logic [OP_W-1:0] op_q;
  logic            ill_q;
  logic            opv_q;

  assign accept = bus.valid_i & ready;

  always_comb begin
    dec_op  = 3'b010;
    dec_ill = 1'b0;
    dec_mdu = 1'b0;
    case (bus.ALUOp)
      2'b00: dec_op = 3'b010;
      2'b10: begin
        case (bus.Funct)
          6'b100000: dec_op = 3'b010;
          6'b100010: dec_op = 3'b110;
          6'b100100: dec_op = 3'b000;
          6'b100101: dec_op = 3'b001;
          6'b101010: dec_op = 3'b111;
`ifdef ALUCTL_MDU_EN
          6'b011000, 6'b011001, 6'b011010, 6'b011011: dec_mdu = 1'b1;
`endif
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_op = 3'b110;
    endcase
  end

  // An MDU accept leaves Op untouched but still clears illegal.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= OP_W'(3'b010);
      ill_q <= 1'b0;
      opv_q <= 1'b0;
    end else begin
      opv_q <= accept & ~dec_mdu;
      if (accept) begin
        ill_q <= dec_ill;
        if (!dec_mdu) op_q <= OP_W'(dec_op);
      end
    end
  end

  assign bus.Op       = op_q;
  assign bus.illegal  = ill_q;
  assign bus.op_valid = opv_q;
  assign bus.ready_o  = ready;
  assign bus.stall    = ~ready;

`ifdef ALUCTL_MDU_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MDU_RUN  = 2'd1,
    MDU_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             start_q;
  logic             div_q;
  logic             sgn_q;

  // Counter holds remaining busy cycles minus one; zero means last busy cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      start_q <= 1'b0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= accept & dec_mdu;
      if (accept && dec_mdu) begin
        cnt_q <= bus.Funct[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        div_q <= bus.Funct[1];
        sgn_q <= ~bus.Funct[0];
      end else if (state_q == MDU_RUN && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (accept && dec_mdu) state_d = MDU_RUN;
      MDU_RUN:  if (cnt_q == '0) state_d = MDU_DONE;
      MDU_DONE: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign ready          = (state_q == IDLE);
  assign bus.mdu_start  = start_q;
  assign bus.mdu_div    = div_q;
  assign bus.mdu_signed = sgn_q;
  assign bus.mdu_busy   = (state_q == MDU_RUN);
  assign bus.mdu_done   = (state_q == MDU_DONE);
  assign bus.hilo_we    = (state_q == MDU_DONE);
  assign bus.dbg_state  = state_q;
`else
  assign ready          = 1'b1;
  assign bus.mdu_start  = 1'b0;
  assign bus.mdu_div    = 1'b0;
  assign bus.mdu_signed = 1'b0;
  assign bus.mdu_busy   = 1'b0;
  assign bus.mdu_done   = 1'b0;
  assign bus.hilo_we    = 1'b0;
  assign bus.dbg_state  = 2'd0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomised and directed bench for alu_control_seq, checked against a timeline-based reference model.
// Works with or without ALUCTL_MDU_EN defined.
module tb_alu_control_seq;
  localparam int OP_W  = 3;
  localparam int MUL_C = 4;
  localparam int DIV_C = 5;
  localparam int CNT_W = 6;
`ifdef ALUCTL_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  localparam logic [5:0] R_FUNCT [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  localparam logic [2:0] R_OP    [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
  localparam logic [5:0] M_FUNCT [4] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011};

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_control_seq_if #(.OP_W(OP_W)) bus ();

  alu_control_seq #(
    .OP_W(OP_W), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  // scoreboard / reference model state
  logic [2:0] exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  bit   m_on, m_div, m_sgn, m_ill, m_opv;
  int   m_t0, m_len;
  logic [2:0] m_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else
      n_pass++;
  endtask

  function automatic void ref_decode(input logic [1:0] a, input logic [5:0] f,
                                     output logic [2:0] op, output bit ill, output bit mdu);
    op  = 3'b010;
    ill = 1'b0;
    mdu = 1'b0;
    if (a == 2'b01 || a == 2'b11) op = 3'b110;
    else if (a == 2'b10) begin
      ill = 1'b1;
      for (int i = 0; i < 5; i++)
        if (f == R_FUNCT[i]) begin op = R_OP[i]; ill = 1'b0; end
      for (int i = 0; i < 4; i++)
        if (f == M_FUNCT[i] && MDU_EN) begin mdu = 1'b1; ill = 1'b0; end
    end
  endfunction

  // Model's ready for cycle c: busy window plus the done cycle after an MDU accept at m_t0.
  function automatic bit m_ready(input int c);
    int rel;
    rel = c - m_t0;
    return !(m_on && rel >= 1 && rel <= m_len + 1);
  endfunction

  task automatic model_reset();
    m_on = 0; m_div = 0; m_sgn = 0; m_ill = 0; m_opv = 0;
    m_t0 = 0; m_len = 0; m_op = 3'b010; cyc = 0;
    exp_q.delete();
  endtask

  task automatic compare_outputs();
    int rel;
    rel = cyc - m_t0;
    check("ready_o",    bus.ready_o,    m_ready(cyc));
    check("stall",      bus.stall,      !m_ready(cyc));
    check("mdu_start",  bus.mdu_start,  m_on && rel == 1);
    check("mdu_busy",   bus.mdu_busy,   m_on && rel >= 1 && rel <= m_len);
    check("mdu_done",   bus.mdu_done,   m_on && rel == m_len + 1);
    check("hilo_we",    bus.hilo_we,    m_on && rel == m_len + 1);
    check("mdu_div",    bus.mdu_div,    m_div);
    check("mdu_signed", bus.mdu_signed, m_sgn);
    check("illegal",    bus.illegal,    m_ill);
    check("op_valid",   bus.op_valid,   m_opv);
    check("Op",         bus.Op,         m_op);
    if (bus.op_valid) begin
      if (exp_q.size() > 0) check("op_q", bus.Op, exp_q.pop_front());
      else check("op_valid_spurious", bus.op_valid, 1'b0);
    end
  endtask

  // driver: present inputs at negedge, model the accept at posedge, compare at next negedge
  task automatic step(input bit v, input logic [1:0] a, input logic [5:0] f);
    logic [2:0] d_op;
    bit d_ill, d_mdu;
    bus.valid_i = v; bus.ALUOp = a; bus.Funct = f;
    @(posedge clk);
    m_opv = 1'b0;
    if (v && m_ready(cyc)) begin
      ref_decode(a, f, d_op, d_ill, d_mdu);
      m_ill = d_ill;
      if (d_mdu) begin
        m_on  = 1'b1;
        m_t0  = cyc;
        m_div = (f == 6'b011010 || f == 6'b011011);
        m_sgn = (f == 6'b011000 || f == 6'b011010);
        m_len = m_div ? DIV_C : MUL_C;
      end else begin
        m_op  = d_op;
        m_opv = 1'b1;
        exp_q.push_back(d_op);
      end
    end
    cyc++;
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic do_reset(input int n);
    bus.valid_i = 1'b0;
    reset = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    model_reset();
    compare_outputs();
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_acc;
    logic [5:0] f;
    bus.valid_i = 1'b0; bus.ALUOp = 2'b00; bus.Funct = 6'b000000;
    model_reset();
    @(negedge clk);

    // reset held two cycles: explicit reset values
    do_reset(2);
    check("rst_Op",      bus.Op,       3'b010);
    check("rst_ready",   bus.ready_o,  1'b1);
    check("rst_opvalid", bus.op_valid, 1'b0);
    check("rst_illegal", bus.illegal,  1'b0);
    check("rst_busy",    bus.mdu_busy, 1'b0);

    // back-to-back legal R-type functs
    for (int i = 0; i < 5; i++) step(1'b1, 2'b10, R_FUNCT[i]);
    step(1'b0, 2'b00, 6'b0);

    // ALUOp 00, 01, then an illegal funct
    step(1'b1, 2'b00, 6'b000000);
    step(1'b1, 2'b01, 6'b000000);
    step(1'b1, 2'b10, 6'b000111);
    step(1'b0, 2'b00, 6'b0);

    // mult, then idle long enough to see the whole run
    step(1'b1, 2'b10, 6'b011000);
    for (int i = 0; i < MUL_C + 3; i++) step(1'b0, 2'b00, 6'b0);

    // divu with a producer holding add until it is accepted
    step(1'b1, 2'b10, 6'b011011);
    done_acc = 1'b0;
    for (int i = 0; i < DIV_C + 6 && !done_acc; i++) begin
      step(1'b1, 2'b10, 6'b100000);
      done_acc = m_opv;
    end
    check("held_req_accepted", bus.op_valid, 1'b1);
    step(1'b0, 2'b00, 6'b0);

    // reset two cycles into a multiply
    step(1'b1, 2'b10, 6'b011001);
    step(1'b0, 2'b00, 6'b0);
    step(1'b0, 2'b00, 6'b0);
    do_reset(1);
    for (int i = 0; i < MUL_C + 2; i++) step(1'b0, 2'b00, 6'b0);

    // random traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset(1);
      case ($urandom_range(0, 2))
        0:       f = 6'($urandom_range(0, 63));
        1:       f = R_FUNCT[$urandom_range(0, 4)];
        default: f = M_FUNCT[$urandom_range(0, 3)];
      endcase
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), f);
    end
    step(1'b0, 2'b00, 6'b0);
    check("op_q_drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
